ifetch_buf: RTL and testbench
=============================

Name: ifetch_buf

Overview:
- Instruction fetch stage directly downstream of the PC register.
- Accepts the current PC, issues one request to instruction memory, and captures the returned word with its PC and PC+4.
- Buffers captured words in a small FIFO feeding decode.
- Supports pipeline flush on redirect (branch/jump) and flags misaligned PCs without touching memory.

Parameters:
- DEPTH, 2, FIFO entries (power of two, >=2).
- NOP, 32'h00000013, instruction word substituted for faulting fetches.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- pc_in  in  32  PC from PC stage
- pc_valid  in  1  pc_in valid
- pc_ready  out  1  PC accepted this cycle; PC stage may advance
- flush  in  1  redirect; drop buffered and in-flight fetches
- imem_req  out  1  memory request strobe, one cycle per request
- imem_addr  out  32  request address
- imem_rvalid  in  1  response valid, >=1 cycle after imem_req
- imem_rdata  in  32  response data
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode consumes head
- inst  out  32  head instruction
- inst_pc  out  32  head PC
- inst_pcadd  out  32  head PC+4
- inst_fault  out  1  head is misaligned-fetch fault

Behaviour:
- Reset is the "Already decided" item: reset rst_n, synchronous, active-low; clock clk.
- On reset: state IDLE, FIFO count 0, rd/wr pointers 0, req_pc 0, all outputs 0. Reset mid-request abandons the request; a later stray imem_rvalid in IDLE is ignored.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding.
  - DISCARD: outstanding request whose response must be dropped.
- Issue (IDLE, pc_valid=1, flush=0, count<DEPTH):
  - pc_ready=1, combinational, same cycle.
  - Aligned (pc_in[1:0]==0): imem_req=1, imem_addr=pc_in; latch req_pc=pc_in; next state WAIT.
  - Misaligned: no imem_req; push {inst=NOP, pc=pc_in, pcadd=pc_in+4, fault=1} at the clock edge; stay IDLE.
- In WAIT/DISCARD, or when count==DEPTH, or when flush=1: pc_ready=0, imem_req=0. imem_addr is 0 whenever imem_req=0.
- Only one request is outstanding at a time. Issuing with count<DEPTH guarantees a slot for its response.
- WAIT & imem_rvalid & !flush: push {imem_rdata, req_pc, req_pc+4, fault=0}; next state IDLE. A new issue is possible the following cycle.
- Flush:
  - FIFO count cleared to 0 and pointers reset at the edge. A pop in the same cycle is irrelevant.
  - WAIT & flush & !imem_rvalid -> DISCARD.
  - WAIT & flush & imem_rvalid -> response dropped, IDLE.
  - DISCARD & imem_rvalid -> IDLE, data dropped, regardless of flush.
  - flush in IDLE blocks issue that cycle only.
- FIFO:
  - inst_valid = (count!=0).
  - inst/inst_pc/inst_pcadd/inst_fault show the head; all 0 when empty.
  - Pop when inst_valid & inst_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
  - Pushed entry becomes visible on inst_valid the cycle after the push edge.
- Latency: PC accepted at cycle T with response at T+k (k>=1); entry visible at T+k+1.
- Arithmetic: pcadd = pc+4 modulo 2^32 (32'hFFFFFFFC -> 0).

Test Plan:
- Reset/basic: release reset, pc_in=0, pc_valid=1, memory latency 1 returning 32'h00500093.
  - pc_ready=1 at T; imem_req=1, imem_addr=0 at T.
  - inst_valid at T+2 with inst=32'h00500093, inst_pc=0, inst_pcadd=4, inst_fault=0.
- Back-pressure: inst_ready=0, sequential PCs 0,4,8.
  - Two entries fill; pc_ready=0 with no imem_req for PC 8 until one pop.
  - After the pop, PC 8 is issued; order 0,4,8 preserved.
- Flush in flight: issue PC 0x10, assert flush at T+1 with latency 3.
  - State DISCARD; response at T+3 dropped; inst_valid stays 0.
  - Next issue accepted at T+4.
- Flush with same-cycle response: flush and imem_rvalid coincide in WAIT.
  - Nothing pushed; state IDLE the next cycle.
- Misaligned: pc_in=32'h00000006.
  - No imem_req; next cycle inst_valid=1, inst=32'h00000013, inst_pc=6, inst_pcadd=0xA, inst_fault=1.
- Wrap and concurrency: pc_in=32'hFFFFFFFC yields inst_pcadd=0. Continuous streaming with inst_ready=1 and push/pop in the same cycle keeps count at 1 over more than 4 pointer wraps.

Source files
------------

// File: rtl/ifetch_buf.sv
// ifetch_buf: single-outstanding instruction fetch with a small decode-side FIFO, flush on redirect and misaligned-PC faults
module ifetch_buf #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pcadd,
  output logic        inst_fault
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0] req_pc;
  logic [31:0] buf_inst [DEPTH];
  logic [31:0] buf_pc [DEPTH];
  logic        buf_fault [DEPTH];
  logic issue, aligned, push_rsp, push_mis, push, pop;
  assign aligned  = pc_in[1:0] == 2'b00;
  assign issue    = rst_n && state == IDLE && pc_valid && !flush && count != CW'(DEPTH);
  assign push_rsp = state == WAIT && imem_rvalid && !flush;
  assign push_mis = issue && !aligned;
  assign push     = push_rsp || push_mis;
  assign pop      = inst_valid && inst_ready;
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = issue && aligned ? WAIT : IDLE;
      WAIT:    state_nx = imem_rvalid ? IDLE : flush ? DISCARD : WAIT;
      DISCARD: state_nx = imem_rvalid ? IDLE : DISCARD;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    pc_ready  = issue;
    imem_req  = issue && aligned;
    imem_addr = imem_req ? pc_in : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      req_pc <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (imem_req) req_pc <= pc_in;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // push is never asserted during flush, so stale writes cannot resurrect dropped entries
  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[wr_ptr]  <= push_rsp ? imem_rdata : NOP;
      buf_pc[wr_ptr]    <= push_rsp ? req_pc : pc_in;
      buf_fault[wr_ptr] <= push_mis;
    end
  end
  assign inst_valid = count != '0;
  assign inst       = inst_valid ? buf_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? buf_pc[rd_ptr] : '0;
  assign inst_pcadd = inst_valid ? buf_pc[rd_ptr] + 32'd4 : '0;
  assign inst_fault = inst_valid && buf_fault[rd_ptr];
endmodule

// File: tb/tb_ifetch_buf.sv
// tb_ifetch_buf: directed scenarios plus a randomized run checked against a queue-based fetch model
module tb_ifetch_buf;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk, rst_n, pc_valid, pc_ready, flush, imem_req, imem_rvalid;
  logic inst_valid, inst_ready, inst_fault;
  logic [31:0] pc_in, imem_addr, imem_rdata, inst, inst_pc, inst_pcadd;
  int compared = 0, mismatched = 0;
  typedef struct {logic [31:0] i; logic [31:0] p; logic f;} ent_t;
  ent_t q[$];
  ent_t h;
  logic mon_en = 0, auto_mem = 0, pend = 0, pend_drop = 0, m_rdy, m_req;
  logic [31:0] pend_pc;
  logic req_seen, busy = 0;
  logic [31:0] req_a, busy_a;
  int cnt;

  ifetch_buf #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_pcadd(inst_pcadd), .inst_fault(inst_fault)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic pop1;
    inst_ready = 1; step; inst_ready = 0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    pc_in = a; pc_valid = 1; step;
    pc_valid = 0; imem_rvalid = 1; imem_rdata = d; step;
    imem_rvalid = 0;
  endtask

  // Memory with random 1..3 cycle latency, used only by the randomized run
  initial forever begin
    @(negedge clk);
    req_seen = imem_req; req_a = imem_addr;
    @(posedge clk); #1;
    if (auto_mem) begin
      imem_rvalid = 0;
      if (req_seen) begin busy = 1; busy_a = req_a; cnt = $urandom_range(0, 2); end
      if (busy) begin
        if (cnt == 0) begin imem_rvalid = 1; imem_rdata = memf(busy_a); busy = 0; end
        else cnt--;
      end
    end else busy = 0;
  end

  // Transaction-level model: visible entries in a queue, at most one pending fetch
  always @(negedge clk) if (mon_en) begin
    m_rdy = pc_valid && !flush && !pend && q.size() < DEPTH;
    m_req = m_rdy && pc_in[1:0] == 2'b00;
    compared++; if (pc_ready !== m_rdy) begin mismatched++; $display("FAIL rnd_pc_ready: got %b want %b", pc_ready, m_rdy); end
    compared++; if (imem_req !== m_req) begin mismatched++; $display("FAIL rnd_imem_req: got %b want %b", imem_req, m_req); end
    compared++; if (imem_addr !== (m_req ? pc_in : 32'h0)) begin mismatched++; $display("FAIL rnd_imem_addr: got %h want %h", imem_addr, m_req ? pc_in : 32'h0); end
    compared++; if (inst_valid !== (q.size() != 0)) begin mismatched++; $display("FAIL rnd_inst_valid: got %b want %b", inst_valid, q.size() != 0); end
    if (q.size() != 0) begin
      h = q[0];
      compared++; if ({inst, inst_pc, inst_pcadd, inst_fault} !== {h.i, h.p, h.p + 32'd4, h.f}) begin
        mismatched++; $display("FAIL rnd_head: got %h/%h/%h/%b want %h/%h/%h/%b", inst, inst_pc, inst_pcadd, inst_fault, h.i, h.p, h.p + 32'd4, h.f);
      end
    end else begin
      compared++; if ({inst, inst_pc, inst_pcadd, inst_fault} !== 97'h0) begin mismatched++; $display("FAIL rnd_empty_head: got %h/%h/%h/%b want 0", inst, inst_pc, inst_pcadd, inst_fault); end
    end
    if (flush) begin
      q.delete();
      if (pend && imem_rvalid) pend = 0;
      else if (pend) pend_drop = 1;
    end else begin
      if (q.size() != 0 && inst_ready) void'(q.pop_front());
      if (pend && imem_rvalid) begin
        if (!pend_drop) q.push_back('{imem_rdata, pend_pc, 1'b0});
        pend = 0;
      end
      if (m_req) begin pend = 1; pend_drop = 0; pend_pc = pc_in; end
      else if (m_rdy) q.push_back('{NOP, pc_in, 1'b1});
    end
  end

  task automatic test_reset;
    rst_n = 0; step; step; #1;
    compared++; if ({pc_ready, imem_req, imem_addr} !== 34'h0) begin mismatched++; $display("FAIL reset_req: got %b/%b/%h want 0", pc_ready, imem_req, imem_addr); end
    compared++; if ({inst_valid, inst, inst_pc, inst_pcadd, inst_fault} !== 98'h0) begin mismatched++; $display("FAIL reset_fifo: got %b/%h/%h/%h/%b want 0", inst_valid, inst, inst_pc, inst_pcadd, inst_fault); end
    rst_n = 1; imem_rvalid = 1; imem_rdata = 32'hDEADBEEF; step;
    imem_rvalid = 0; #1;
    compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL reset_stray_rvalid: got %b want 0", inst_valid); end
    pc_in = 32'h50; pc_valid = 1; step;
    pc_valid = 0; rst_n = 0; step;
    rst_n = 1; imem_rvalid = 1; step;
    imem_rvalid = 0; #1;
    compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL reset_mid_request: got %b want 0", inst_valid); end
    rst_n = 0; step;
  endtask

  task automatic test_basic;
    rst_n = 1; pc_in = 0; pc_valid = 1; #1;
    compared++; if (pc_ready !== 1'b1) begin mismatched++; $display("FAIL basic_pc_ready: got %b want 1", pc_ready); end
    compared++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin mismatched++; $display("FAIL basic_req: got %b/%h want 1/0", imem_req, imem_addr); end
    step; pc_valid = 0; imem_rvalid = 1; imem_rdata = 32'h00500093; #1;
    compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL basic_early_valid: got %b want 0", inst_valid); end
    step; imem_rvalid = 0; #1;
    compared++; if ({inst_valid, inst, inst_pc, inst_pcadd, inst_fault} !== {1'b1, 32'h00500093, 32'h0, 32'h4, 1'b0}) begin
      mismatched++; $display("FAIL basic_head: got %b/%h/%h/%h/%b want 1/00500093/0/4/0", inst_valid, inst, inst_pc, inst_pcadd, inst_fault);
    end
    pop1; #1;
    compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL basic_pop: got %b want 0", inst_valid); end
  endtask

  task automatic test_backpressure;
    fetch(32'h0, 32'hA0); fetch(32'h4, 32'hA4);
    pc_in = 32'h8; pc_valid = 1; #1;
    compared++; if ({pc_ready, imem_req} !== 2'b00) begin mismatched++; $display("FAIL bp_full_0: got %b/%b want 0/0", pc_ready, imem_req); end
    step; inst_ready = 1; #1;
    compared++; if ({pc_ready, imem_req} !== 2'b00) begin mismatched++; $display("FAIL bp_full_1: got %b/%b want 0/0", pc_ready, imem_req); end
    compared++; if (inst_pc !== 32'h0) begin mismatched++; $display("FAIL bp_head0: got %h want 0", inst_pc); end
    step; inst_ready = 0; #1;
    compared++; if ({pc_ready, imem_req, imem_addr} !== {2'b11, 32'h8}) begin mismatched++; $display("FAIL bp_issue8: got %b/%b/%h want 1/1/8", pc_ready, imem_req, imem_addr); end
    step; pc_valid = 0; imem_rvalid = 1; imem_rdata = 32'hA8; step; imem_rvalid = 0; #1;
    compared++; if ({inst_pc, inst} !== {32'h4, 32'hA4}) begin mismatched++; $display("FAIL bp_head4: got %h/%h want 4/a4", inst_pc, inst); end
    pop1; #1;
    compared++; if ({inst_pc, inst} !== {32'h8, 32'hA8}) begin mismatched++; $display("FAIL bp_head8: got %h/%h want 8/a8", inst_pc, inst); end
    pop1; #1;
    compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL bp_drained: got %b want 0", inst_valid); end
  endtask

  task automatic test_flush_inflight;
    pc_in = 32'h10; pc_valid = 1; #1;
    compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL fl_issue: got %b want 1", imem_req); end
    step; pc_valid = 0; flush = 1;
    step; flush = 0; pc_in = 32'h20; pc_valid = 1; #1;
    compared++; if ({pc_ready, imem_req} !== 2'b00) begin mismatched++; $display("FAIL fl_discard_t2: got %b/%b want 0/0", pc_ready, imem_req); end
    step; imem_rvalid = 1; imem_rdata = 32'hBAD; #1;
    compared++; if (pc_ready !== 1'b0) begin mismatched++; $display("FAIL fl_discard_t3: got %b want 0", pc_ready); end
    step; imem_rvalid = 0; #1;
    compared++; if ({pc_ready, inst_valid} !== 2'b10) begin mismatched++; $display("FAIL fl_t4: got ready %b valid %b want 1/0", pc_ready, inst_valid); end
    step; pc_valid = 0; imem_rvalid = 1; imem_rdata = 32'hC20; step; imem_rvalid = 0; #1;
    compared++; if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h20, 32'hC20}) begin mismatched++; $display("FAIL fl_next: got %b/%h/%h want 1/20/c20", inst_valid, inst_pc, inst); end
    pop1;
  endtask

  task automatic test_flush_same_cycle;
    fetch(32'h40, 32'hC40);
    pc_in = 32'h30; pc_valid = 1; #1;
    compared++; if (imem_req !== 1'b1) begin mismatched++; $display("FAIL fs_issue: got %b want 1", imem_req); end
    step; pc_valid = 0; flush = 1; imem_rvalid = 1; imem_rdata = 32'hBAD;
    step; flush = 0; imem_rvalid = 0; pc_in = 32'h34; pc_valid = 1; #1;
    compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL fs_cleared: got %b want 0", inst_valid); end
    compared++; if (pc_ready !== 1'b1) begin mismatched++; $display("FAIL fs_idle: got %b want 1", pc_ready); end
    step; pc_valid = 0; imem_rvalid = 1; imem_rdata = 32'hC34; step; imem_rvalid = 0; #1;
    compared++; if ({inst_pc, inst} !== {32'h34, 32'hC34}) begin mismatched++; $display("FAIL fs_next: got %h/%h want 34/c34", inst_pc, inst); end
    pop1;
  endtask

  task automatic test_misaligned;
    pc_in = 32'h6; pc_valid = 1; #1;
    compared++; if ({pc_ready, imem_req, imem_addr} !== {2'b10, 32'h0}) begin mismatched++; $display("FAIL mis_req: got %b/%b/%h want 1/0/0", pc_ready, imem_req, imem_addr); end
    step; pc_valid = 0; #1;
    compared++; if ({inst_valid, inst, inst_pc, inst_pcadd, inst_fault} !== {1'b1, NOP, 32'h6, 32'hA, 1'b1}) begin
      mismatched++; $display("FAIL mis_head: got %b/%h/%h/%h/%b want 1/%h/6/a/1", inst_valid, inst, inst_pc, inst_pcadd, inst_fault, NOP);
    end
    pop1;
  endtask

  task automatic test_wrap_stream;
    logic [31:0] prev;
    fetch(32'hFFFFFFFC, 32'hC0DE); #1;
    compared++; if ({inst_pc, inst_pcadd} !== {32'hFFFFFFFC, 32'h0}) begin mismatched++; $display("FAIL wrap_pcadd: got %h/%h want fffffffc/0", inst_pc, inst_pcadd); end
    pop1;
    inst_ready = 1; pc_valid = 1; prev = 0;
    for (int i = 0; i < 12; i++) begin
      pc_in = 32'h100 + 32'(4 * i) + 32'h2; #1;
      compared++; if (pc_ready !== 1'b1) begin mismatched++; $display("FAIL stream_ready_%0d: got %b want 1", i, pc_ready); end
      if (i > 0) begin
        compared++; if ({inst_valid, inst_pc} !== {1'b1, prev}) begin mismatched++; $display("FAIL stream_head_%0d: got %b/%h want 1/%h", i, inst_valid, inst_pc, prev); end
      end
      prev = pc_in; step;
    end
    pc_valid = 0; step; inst_ready = 0; #1;
    compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("FAIL stream_drained: got %b want 0", inst_valid); end
  endtask

  task automatic test_random;
    rst_n = 0; step;
    q.delete(); pend = 0; pend_drop = 0;
    rst_n = 1; auto_mem = 1; mon_en = 1;
    for (int c = 0; c < 3000; c++) begin
      pc_valid = $urandom_range(0, 9) < 7;
      pc_in = ($urandom & 32'hFFFFFFFC) | ($urandom_range(0, 7) == 0 ? 32'($urandom_range(1, 3)) : 32'h0);
      flush = $urandom_range(0, 19) == 0;
      inst_ready = $urandom_range(0, 1) == 1;
      step;
    end
    pc_valid = 0; flush = 0; inst_ready = 1;
    repeat (8) step;
    mon_en = 0; auto_mem = 0; imem_rvalid = 0; inst_ready = 0;
  endtask

  initial begin
    rst_n = 0; pc_in = 0; pc_valid = 0; flush = 0; imem_rvalid = 0; imem_rdata = 0; inst_ready = 0;
    test_reset;
    test_basic;
    test_backpressure;
    test_flush_inflight;
    test_flush_same_cycle;
    test_misaligned;
    test_wrap_stream;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
